ysyx_23060025_axi_bridge: RTL and testbench

Downstream neighbour of the CPU core. Arbitrates between the core's instruction-fetch port (icache refill, burst reads) and data port (LSU, single-beat read/write). Converts the winning request into one AXI4 master transaction. Returns read data, write completion and a bus-error pulse to the requester. Only one transaction is in flight at a time.

---
 rtl/ysyx_23060025_axi_bridge_pkg.sv | 17 +
 rtl/ysyx_23060025_axi_bridge.sv | 199 +++++++++++++++++++
 tb/tb_ysyx_23060025_axi_bridge.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060025_axi_bridge_pkg.sv
// rtl/ysyx_23060025_axi_bridge_pkg.sv - bridge state encodings and AXI constants
package ysyx_23060025_axi_bridge_pkg;

    typedef enum logic [2:0] {
        BRG_IDLE,
        BRG_I_AR,
        BRG_I_R,
        BRG_D_AR,
        BRG_D_R,
        BRG_D_AW,
        BRG_D_B
    } brg_state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/ysyx_23060025_axi_bridge.sv
// rtl/ysyx_23060025_axi_bridge.sv - fetch/LSU arbiter and single-outstanding AXI4 master
module ysyx_23060025_axi_bridge
    import ysyx_23060025_axi_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,

    input  logic [ADDR_WIDTH-1:0]   inst_paddr,
    input  logic [7:0]              inst_plen,
    input  logic [2:0]              inst_psize,
    input  logic                    inst_psel,
    output logic                    inst_pvalid,
    output logic                    inst_plast,
    output logic [DATA_WIDTH-1:0]   inst_prdata,

    input  logic [ADDR_WIDTH-1:0]   data_paddr,
    input  logic [2:0]              data_psize,
    input  logic                    data_psel,
    input  logic                    data_pwrite,
    input  logic [DATA_WIDTH-1:0]   data_pwdata,
    input  logic [DATA_WIDTH/8-1:0] data_pwstrb,
    output logic [DATA_WIDTH-1:0]   data_prdata,
    output logic                    data_pvalid,
    output logic                    bus_err_o,

    output logic [ADDR_WIDTH-1:0]   axi_araddr,
    output logic [7:0]              axi_arlen,
    output logic [2:0]              axi_arsize,
    output logic [1:0]              axi_arburst,
    output logic                    axi_arvalid,
    input  logic                    axi_arready,

    input  logic [DATA_WIDTH-1:0]   axi_rdata,
    input  logic [1:0]              axi_rresp,
    input  logic                    axi_rlast,
    input  logic                    axi_rvalid,
    output logic                    axi_rready,

    output logic [ADDR_WIDTH-1:0]   axi_awaddr,
    output logic [7:0]              axi_awlen,
    output logic [2:0]              axi_awsize,
    output logic [1:0]              axi_awburst,
    output logic                    axi_awvalid,
    input  logic                    axi_awready,

    output logic [DATA_WIDTH-1:0]   axi_wdata,
    output logic [DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                    axi_wlast,
    output logic                    axi_wvalid,
    input  logic                    axi_wready,

    input  logic                    axi_bvalid,
    input  logic [1:0]              axi_bresp,
    output logic                    axi_bready
);

    brg_state_t state;
    logic       aw_done;
    logic       w_done;
    logic       err_seen;

    logic aw_hs;
    logic w_hs;
    logic aw_ok;
    logic w_ok;
    logic r_err;
    logic b_err;

    assign aw_hs = axi_awvalid && axi_awready;
    assign w_hs  = axi_wvalid && axi_wready;
    assign aw_ok = aw_done || aw_hs;
    assign w_ok  = w_done || w_hs;
    assign r_err = axi_rresp != AXI_RESP_OKAY;
    assign b_err = axi_bresp != AXI_RESP_OKAY;

    // Upstream returns are combinational so a zero-wait slave adds no latency.
    assign inst_pvalid = (state == BRG_I_R) && axi_rvalid;
    assign inst_plast  = inst_pvalid && axi_rlast;
    assign inst_prdata = axi_rdata;
    assign data_prdata = axi_rdata;
    assign data_pvalid = ((state == BRG_D_R) && axi_rvalid) ||
                         ((state == BRG_D_B) && axi_bvalid);

    // A burst reports an error on its last beat if any beat carried a bad response.
    assign bus_err_o = ((state == BRG_I_R) && axi_rvalid && axi_rlast && (r_err || err_seen)) ||
                       ((state == BRG_D_R) && axi_rvalid && r_err) ||
                       ((state == BRG_D_B) && axi_bvalid && b_err);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= BRG_IDLE;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            err_seen    <= 1'b0;
            axi_araddr  <= '0;
            axi_arlen   <= '0;
            axi_arsize  <= '0;
            axi_arburst <= '0;
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b0;
            axi_awaddr  <= '0;
            axi_awlen   <= '0;
            axi_awsize  <= '0;
            axi_awburst <= '0;
            axi_awvalid <= 1'b0;
            axi_wdata   <= '0;
            axi_wstrb   <= '0;
            axi_wlast   <= 1'b0;
            axi_wvalid  <= 1'b0;
            axi_bready  <= 1'b0;
        end else begin
            case (state)
                BRG_IDLE: begin
                    // Fixed priority: the LSU always beats the fetch port.
                    if (data_psel) begin
                        if (data_pwrite) begin
                            axi_awaddr  <= data_paddr;
                            axi_awlen   <= 8'd0;
                            axi_awsize  <= data_psize;
                            axi_awburst <= AXI_BURST_INCR;
                            axi_awvalid <= 1'b1;
                            axi_wdata   <= data_pwdata;
                            axi_wstrb   <= data_pwstrb;
                            axi_wlast   <= 1'b1;
                            axi_wvalid  <= 1'b1;
                            aw_done     <= 1'b0;
                            w_done      <= 1'b0;
                            state       <= BRG_D_AW;
                        end else begin
                            axi_araddr  <= data_paddr;
                            axi_arlen   <= 8'd0;
                            axi_arsize  <= data_psize;
                            axi_arburst <= AXI_BURST_INCR;
                            axi_arvalid <= 1'b1;
                            state       <= BRG_D_AR;
                        end
                    end else if (inst_psel) begin
                        axi_araddr  <= inst_paddr;
                        axi_arlen   <= inst_plen;
                        axi_arsize  <= inst_psize;
                        axi_arburst <= AXI_BURST_INCR;
                        axi_arvalid <= 1'b1;
                        err_seen    <= 1'b0;
                        state       <= BRG_I_AR;
                    end
                end
                BRG_I_AR, BRG_D_AR: begin
                    if (axi_arready) begin
                        axi_arvalid <= 1'b0;
                        axi_rready  <= 1'b1;
                        state       <= (state == BRG_I_AR) ? BRG_I_R : BRG_D_R;
                    end
                end
                BRG_I_R: begin
                    if (axi_rvalid) begin
                        if (r_err) begin
                            err_seen <= 1'b1;
                        end
                        if (axi_rlast) begin
                            axi_rready <= 1'b0;
                            state      <= BRG_IDLE;
                        end
                    end
                end
                BRG_D_R: begin
                    if (axi_rvalid) begin
                        axi_rready <= 1'b0;
                        state      <= BRG_IDLE;
                    end
                end
                BRG_D_AW: begin
                    if (aw_hs) begin
                        axi_awvalid <= 1'b0;
                        aw_done     <= 1'b1;
                    end
                    if (w_hs) begin
                        axi_wvalid <= 1'b0;
                        w_done     <= 1'b1;
                    end
                    if (aw_ok && w_ok) begin
                        axi_bready <= 1'b1;
                        state      <= BRG_D_B;
                    end
                end
                BRG_D_B: begin
                    if (axi_bvalid) begin
                        axi_bready <= 1'b0;
                        state      <= BRG_IDLE;
                    end
                end
                default: state <= BRG_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060025_axi_bridge.sv
// tb/tb_ysyx_23060025_axi_bridge.sv - self-checking bench with directed and randomized transactions
module tb_ysyx_23060025_axi_bridge;

    logic        clock;
    logic        reset;
    logic [31:0] inst_paddr;
    logic [7:0]  inst_plen;
    logic [2:0]  inst_psize;
    logic        inst_psel;
    logic        inst_pvalid;
    logic        inst_plast;
    logic [31:0] inst_prdata;
    logic [31:0] data_paddr;
    logic [2:0]  data_psize;
    logic        data_psel;
    logic        data_pwrite;
    logic [31:0] data_pwdata;
    logic [3:0]  data_pwstrb;
    logic [31:0] data_prdata;
    logic        data_pvalid;
    logic        bus_err_o;
    logic [31:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [31:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic [2:0]  axi_awsize;
    logic [1:0]  axi_awburst;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wlast;
    logic        axi_wvalid;
    logic        axi_wready;
    logic        axi_bvalid;
    logic [1:0]  axi_bresp;
    logic        axi_bready;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_23060025_axi_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .inst_paddr(inst_paddr), .inst_plen(inst_plen), .inst_psize(inst_psize),
        .inst_psel(inst_psel), .inst_pvalid(inst_pvalid), .inst_plast(inst_plast),
        .inst_prdata(inst_prdata),
        .data_paddr(data_paddr), .data_psize(data_psize), .data_psel(data_psel),
        .data_pwrite(data_pwrite), .data_pwdata(data_pwdata), .data_pwstrb(data_pwstrb),
        .data_prdata(data_prdata), .data_pvalid(data_pvalid), .bus_err_o(bus_err_o),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_arburst(axi_arburst), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bvalid(axi_bvalid), .axi_bresp(axi_bresp), .axi_bready(axi_bready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave accepts AR after ar_wait stall cycles, then returns len+1 beats with random gaps.
    task automatic do_fetch(input logic [31:0] addr, input logic [7:0] len, input int ar_wait,
                            input int r_wait, input bit fixed, input bit pre);
        logic [31:0] beats[$];
        int nw;
        for (int i = 0; i <= int'(len); i++)
            beats.push_back(fixed ? 32'((i + 1) * 'h11) : $urandom);
        if (!pre) step();
        inst_psel = 1'b1; inst_paddr = addr; inst_plen = len; inst_psize = 3'd2;
        chk("f_idle_arvalid", axi_arvalid, 0);
        step();
        chk("f_araddr", axi_araddr, addr);
        chk("f_arlen", axi_arlen, len);
        chk("f_arburst", axi_arburst, 2'b01);
        chk("f_arsize", axi_arsize, 3'd2);
        for (int w = 0; w <= ar_wait; w++) begin
            chk("f_arvalid_hold", axi_arvalid, 1);
            chk("f_araddr_stable", axi_araddr, addr);
            axi_arready = (w == ar_wait);
            step();
        end
        axi_arready = 1'b0;
        chk("f_arvalid_drop", axi_arvalid, 0);
        chk("f_rready", axi_rready, 1);
        for (int i = 0; i <= int'(len); i++) begin
            nw = $urandom_range(0, r_wait);
            repeat (nw) begin
                axi_rvalid = 1'b0;
                #1 chk("f_gap_pvalid", inst_pvalid, 0);
                step();
            end
            axi_rvalid = 1'b1; axi_rdata = beats[i]; axi_rlast = (i == int'(len)); axi_rresp = 2'b00;
            #1;
            chk("f_pvalid", inst_pvalid, 1);
            chk("f_prdata", inst_prdata, beats[i]);
            chk("f_plast", inst_plast, (i == int'(len)));
            chk("f_bus_err", bus_err_o, 0);
            step();
        end
        axi_rvalid = 1'b0; axi_rlast = 1'b0; inst_psel = 1'b0;
        #1;
        chk("f_end_rready", axi_rready, 0);
        chk("f_end_pvalid", inst_pvalid, 0);
        chk("f_end_arvalid", axi_arvalid, 0);
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] d,
                           input int ar_wait, input int r_wait, input logic [1:0] resp);
        step();
        data_psel = 1'b1; data_pwrite = 1'b0; data_paddr = addr; data_psize = size;
        chk("l_idle_arvalid", axi_arvalid, 0);
        step();
        chk("l_araddr", axi_araddr, addr);
        chk("l_arlen", axi_arlen, 0);
        chk("l_arsize", axi_arsize, size);
        chk("l_arburst", axi_arburst, 2'b01);
        for (int w = 0; w <= ar_wait; w++) begin
            chk("l_arvalid_hold", axi_arvalid, 1);
            axi_arready = (w == ar_wait);
            step();
        end
        axi_arready = 1'b0;
        chk("l_arvalid_drop", axi_arvalid, 0);
        chk("l_rready", axi_rready, 1);
        repeat (r_wait) begin
            axi_rvalid = 1'b0;
            #1 chk("l_wait_pvalid", data_pvalid, 0);
            step();
        end
        axi_rvalid = 1'b1; axi_rdata = d; axi_rresp = resp; axi_rlast = 1'b1;
        #1;
        chk("l_pvalid", data_pvalid, 1);
        chk("l_prdata", data_prdata, d);
        chk("l_bus_err", bus_err_o, (resp != 2'b00));
        step();
        axi_rvalid = 1'b0; axi_rresp = 2'b00; axi_rlast = 1'b0; data_psel = 1'b0;
        #1;
        chk("l_end_pvalid", data_pvalid, 0);
        chk("l_end_rready", axi_rready, 0);
        chk("l_end_bus_err", bus_err_o, 0);
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                            input int aw_wait, input int w_wait, input int b_wait,
                            input logic [1:0] resp, input bit with_inst);
        int last;
        last = (aw_wait > w_wait) ? aw_wait : w_wait;
        step();
        data_psel = 1'b1; data_pwrite = 1'b1; data_paddr = addr; data_psize = 3'd2;
        data_pwdata = wd; data_pwstrb = ws;
        if (with_inst) inst_psel = 1'b1;
        chk("s_idle_awvalid", axi_awvalid, 0);
        step();
        chk("s_awaddr", axi_awaddr, addr);
        chk("s_awlen", axi_awlen, 0);
        chk("s_awburst", axi_awburst, 2'b01);
        chk("s_wdata", axi_wdata, wd);
        chk("s_wstrb", axi_wstrb, ws);
        chk("s_wlast", axi_wlast, 1);
        for (int c = 0; c <= last; c++) begin
            chk("s_awvalid", axi_awvalid, (c <= aw_wait));
            chk("s_wvalid", axi_wvalid, (c <= w_wait));
            chk("s_bready_early", axi_bready, 0);
            chk("s_arvalid_quiet", axi_arvalid, 0);
            axi_awready = (c == aw_wait);
            axi_wready  = (c == w_wait);
            step();
        end
        axi_awready = 1'b0; axi_wready = 1'b0;
        chk("s_awvalid_done", axi_awvalid, 0);
        chk("s_wvalid_done", axi_wvalid, 0);
        chk("s_bready", axi_bready, 1);
        repeat (b_wait) begin
            axi_bvalid = 1'b0;
            #1 chk("s_wait_pvalid", data_pvalid, 0);
            step();
        end
        axi_bvalid = 1'b1; axi_bresp = resp;
        #1;
        chk("s_pvalid", data_pvalid, 1);
        chk("s_bus_err", bus_err_o, (resp != 2'b00));
        step();
        axi_bvalid = 1'b0; axi_bresp = 2'b00; data_psel = 1'b0; data_pwrite = 1'b0;
        #1;
        chk("s_end_pvalid", data_pvalid, 0);
        chk("s_end_bready", axi_bready, 0);
        chk("s_end_bus_err", bus_err_o, 0);
        chk("s_dead_arvalid", axi_arvalid, 0);
    endtask

    initial begin
        logic [31:0] a;
        int kind;
        reset = 1'b1;
        inst_paddr = '0; inst_plen = '0; inst_psize = '0; inst_psel = 1'b0;
        data_paddr = '0; data_psize = '0; data_psel = 1'b0; data_pwrite = 1'b0;
        data_pwdata = '0; data_pwstrb = '0;
        axi_arready = 1'b0; axi_rdata = '0; axi_rresp = '0; axi_rlast = 1'b0; axi_rvalid = 1'b0;
        axi_awready = 1'b0; axi_wready = 1'b0; axi_bvalid = 1'b0; axi_bresp = '0;
        step();
        step();
        chk("rst_arvalid", axi_arvalid, 0);
        chk("rst_rready", axi_rready, 0);
        chk("rst_awvalid", axi_awvalid, 0);
        chk("rst_wvalid", axi_wvalid, 0);
        chk("rst_bready", axi_bready, 0);
        chk("rst_araddr", axi_araddr, 0);
        chk("rst_awaddr", axi_awaddr, 0);
        chk("rst_wdata", axi_wdata, 0);
        chk("rst_inst_pvalid", inst_pvalid, 0);
        chk("rst_data_pvalid", data_pvalid, 0);
        chk("rst_bus_err", bus_err_o, 0);
        reset = 1'b0;

        do_fetch(32'h3000_0000, 8'd3, 0, 0, 1'b1, 1'b0);
        do_load(32'h8000_0010, 3'd2, 32'hDEADBEEF, 0, 3, 2'b00);
        do_store(32'h8000_0020, 32'hCAFE0000, 4'b1100, 0, 3, 0, 2'b00, 1'b0);

        inst_paddr = 32'h3000_0100; inst_plen = 8'd1; inst_psize = 3'd2;
        do_store(32'h8000_0040, 32'h1234_5678, 4'b1111, 1, 1, 1, 2'b00, 1'b1);
        do_fetch(32'h3000_0100, 8'd1, 0, 0, 1'b0, 1'b1);

        do_store(32'h8000_0080, 32'h0000_00AA, 4'b0001, 2, 0, 0, 2'b10, 1'b0);

        step();
        inst_psel = 1'b1; inst_paddr = 32'h4000_0100; inst_plen = 8'd3; inst_psize = 3'd2;
        step();
        chk("r_arvalid", axi_arvalid, 1);
        axi_arready = 1'b1;
        step();
        axi_arready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            axi_rvalid = 1'b1; axi_rdata = $urandom; axi_rlast = 1'b0;
            #1 chk("r_beat_pvalid", inst_pvalid, 1);
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0; inst_psel = 1'b0;
        #1;
        chk("r_arvalid_clear", axi_arvalid, 0);
        chk("r_rready_clear", axi_rready, 0);
        chk("r_pvalid_clear", inst_pvalid, 0);
        chk("r_araddr_clear", axi_araddr, 0);
        step();
        axi_rvalid = 1'b0;
        chk("r_idle_arvalid", axi_arvalid, 0);

        for (int n = 0; n < 24; n++) begin
            kind = $urandom_range(0, 2);
            a = $urandom & 32'hFFFF_FFFC;
            case (kind)
                0: do_fetch(a, 8'($urandom_range(0, 7)), $urandom_range(0, 3), 2, 1'b0, 1'b0);
                1: do_load(a, 3'($urandom_range(0, 2)), $urandom, $urandom_range(0, 3),
                           $urandom_range(0, 3), $urandom_range(0, 1) ? 2'b10 : 2'b00);
                default: do_store(a, $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 3),
                                  $urandom_range(0, 3), $urandom_range(0, 2),
                                  $urandom_range(0, 1) ? 2'b11 : 2'b00, 1'b0);
            endcase
        end

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
